// File: rtl/sfifo_param_if.sv
// Handshake and status bundle for sfifo_param. The FIFO itself is the slave;
// the producer/consumer side is the master.
interface sfifo_param_if #(
  parameter int WIDTH      = 3,
  parameter int DEPTH_LOG2 = 6
);
  logic                  CLR;
  logic [WIDTH-1:0]      WDATA;
  logic                  WE;
  logic                  RE;
  logic                  ERR_CLR;
  logic [WIDTH-1:0]      RDATA;
  logic                  RVALID;
  logic [DEPTH_LOG2:0]   LEVEL;
  logic                  FULL;
  logic                  EMPTY;
  logic                  AFULL;
  logic                  AEMPTY;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport slave (
    input  CLR, WDATA, WE, RE, ERR_CLR,
    output RDATA, RVALID, LEVEL, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW
  );

  modport master (
    output CLR, WDATA, WE, RE, ERR_CLR,
    input  RDATA, RVALID, LEVEL, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty flags,
// synchronous flush and optional sticky error flags (macro BFIFO_ERR_FLAG_EN).
//
// Handshake: a write is taken on a rising edge when WE=1 and FULL=0; a read is
// taken when RE=1 and EMPTY=0, and its data appears on RDATA with RVALID=1 in
// the following cycle. There is no back-pressure beyond FULL/EMPTY.
module sfifo_param #(
  parameter int WIDTH        = 3,
  parameter int DEPTH_LOG2   = 6,
  parameter int AFULL_LEVEL  = 60,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  sfifo_param_if.slave bus
);
  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  LW       = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_L  = LW'(AFULL_LEVEL);
  localparam logic [DEPTH_LOG2:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   level;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come only from the level register, so they never glitch on inputs.
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // Reset and flush both suppress any data movement in the same cycle.
  assign wr_ok = RESET & ~bus.CLR & bus.WE & ~full;
  assign rd_ok = RESET & ~bus.CLR & bus.RE & ~empty;

  always_ff @(posedge CLOCK) begin
    if (wr_ok) begin
      mem[wptr] <= bus.WDATA;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (bus.CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // RDATA survives a flush; only RVALID is dropped.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (bus.CLR) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) rdata <= mem[rptr];
    end
  end

  assign bus.RDATA  = rdata;
  assign bus.RVALID = rvalid;
  assign bus.LEVEL  = level;
  assign bus.FULL   = full;
  assign bus.EMPTY  = empty;
  assign bus.AFULL  = (level >= AFULL_L);
  assign bus.AEMPTY = (level <= AEMPTY_L);

`ifdef BFIFO_ERR_FLAG_EN
  logic overflow;
  logic underflow;

  // A set condition in the same cycle as ERR_CLR wins.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.WE & full & ~bus.CLR) overflow <= 1'b1;
      else if (bus.ERR_CLR)         overflow <= 1'b0;
      if (bus.RE & empty & ~bus.CLR) underflow <= 1'b1;
      else if (bus.ERR_CLR)          underflow <= 1'b0;
    end
  end

  assign bus.OVERFLOW  = overflow;
  assign bus.UNDERFLOW = underflow;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.ERR_CLR;
  assign bus.OVERFLOW   = 1'b0;
  assign bus.UNDERFLOW  = 1'b0;
`endif
endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param: a vector table for the basic write/read and
// error-flag handshakes, then hand sequences for fill, streaming, flush, reset.
module tb_sfifo_param;
  localparam int WIDTH = 3;
  localparam int DL2   = 6;
  localparam int DEPTH = 64;
`ifdef BFIFO_ERR_FLAG_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLOCK = ~CLOCK;

  sfifo_param_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) bus ();

  sfifo_param #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DL2), .AFULL_LEVEL(60), .AEMPTY_LEVEL(4)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic             clr;
    logic             we;
    logic             re;
    logic             err_clr;
    logic [WIDTH-1:0] wdata;
    logic [DL2:0]     exp_level;
    logic             exp_rvalid;
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_ufl;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic clr, input logic we, input logic re,
                       input logic err_clr, input logic [WIDTH-1:0] wdata);
    bus.CLR = clr; bus.WE = we; bus.RE = re; bus.ERR_CLR = err_clr; bus.WDATA = wdata;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rdata"},  32'(bus.RDATA), 0);
    chk({tag, " rvalid"}, 32'(bus.RVALID), 0);
    chk({tag, " level"},  32'(bus.LEVEL), 0);
    chk({tag, " full"},   32'(bus.FULL), 0);
    chk({tag, " empty"},  32'(bus.EMPTY), 1);
    chk({tag, " afull"},  32'(bus.AFULL), 0);
    chk({tag, " aempty"}, 32'(bus.AEMPTY), 1);
    chk({tag, " ovf"},    32'(bus.OVERFLOW), 0);
    chk({tag, " udf"},    32'(bus.UNDERFLOW), 0);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    drive(0, 1, 0, 0, d);
    step();
    exp_q.push_back(d);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    int lvl;

    // Starts from empty just after reset; 'exp_ufl' uses ERR for flag builds.
    vecs[0] = '{0, 1, 0, 0, 3'd5, 1, 0, 0, 0};   // write 5
    vecs[1] = '{0, 0, 1, 0, 3'd0, 0, 1, 5, 0};   // read 5
    vecs[2] = '{0, 0, 0, 0, 3'd0, 0, 0, 5, 0};   // idle, RDATA held
    vecs[3] = '{0, 0, 1, 0, 3'd0, 0, 0, 5, ERR}; // read while empty
    vecs[4] = '{0, 0, 0, 1, 3'd0, 0, 0, 5, 0};   // clear flag
    vecs[5] = '{0, 1, 1, 0, 3'd3, 1, 0, 5, ERR}; // WE+RE at empty: write only
    vecs[6] = '{0, 1, 1, 0, 3'd6, 1, 1, 3, ERR}; // WE+RE at level 1
    vecs[7] = '{0, 0, 0, 1, 3'd0, 1, 0, 3, 0};
    vecs[8] = '{0, 0, 1, 0, 3'd0, 0, 1, 6, 0};

    drive(0, 0, 0, 0, '0);
    RESET = 1'b0;
    repeat (3) step();
    chk_reset_state("reset");
    RESET = 1'b1;
    step();
    chk_reset_state("idle");

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].clr, vecs[i].we, vecs[i].re, vecs[i].err_clr, vecs[i].wdata);
      step();
      chk($sformatf("vec%0d level", i),  32'(bus.LEVEL),  32'(vecs[i].exp_level));
      chk($sformatf("vec%0d empty", i),  32'(bus.EMPTY),  32'(vecs[i].exp_level == 0));
      chk($sformatf("vec%0d rvalid", i), 32'(bus.RVALID), 32'(vecs[i].exp_rvalid));
      chk($sformatf("vec%0d rdata", i),  32'(bus.RDATA),  32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d udf", i),    32'(bus.UNDERFLOW), 32'(vecs[i].exp_ufl));
    end
    drive(0, 0, 0, 0, '0);

    // Fill to full with 0..7 repeating
    for (int i = 0; i < DEPTH; i++) begin
      push_word(WIDTH'(i % 8));
      chk($sformatf("fill%0d level", i), 32'(bus.LEVEL), 32'(i + 1));
      chk($sformatf("fill%0d afull", i), 32'(bus.AFULL), 32'(i + 1 >= 60));
      chk($sformatf("fill%0d full", i),  32'(bus.FULL),  32'(i + 1 == DEPTH));
    end
    drive(0, 1, 0, 0, 3'd7);
    step();
    chk("overfill level", 32'(bus.LEVEL), 64);
    chk("overfill ovf", 32'(bus.OVERFLOW), 32'(ERR));
    drive(0, 1, 1, 0, 3'd1);
    step();
    d = exp_q.pop_front();
    chk("full wr+rd level", 32'(bus.LEVEL), 63);
    chk("full wr+rd rvalid", 32'(bus.RVALID), 1);
    chk("full wr+rd rdata", 32'(bus.RDATA), 32'(d));
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(0, 0, 1, 0, '0);
      step();
      d = exp_q.pop_front();
      chk($sformatf("drain%0d rdata", i), 32'(bus.RDATA), 32'(d));
      chk($sformatf("drain%0d rvalid", i), 32'(bus.RVALID), 1);
    end
    drive(0, 0, 0, 0, '0);
    step();
    chk("drain empty", 32'(bus.EMPTY), 1);
    chk("drain rvalid", 32'(bus.RVALID), 0);
    chk("drain udf", 32'(bus.UNDERFLOW), 0);
    chk("drain ovf held", 32'(bus.OVERFLOW), 32'(ERR));
    drive(0, 0, 0, 1, '0);
    step();
    chk("err_clr ovf", 32'(bus.OVERFLOW), 0);

    // Sustained WE+RE at level 10 across several pointer wraps
    for (int i = 0; i < 10; i++) push_word(WIDTH'((i * 3) % 8));
    for (int i = 0; i < 200; i++) begin
      d = WIDTH'((i * 5 + 1) % 8);
      drive(0, 1, 1, 0, d);
      step();
      exp_q.push_back(d);
      d = exp_q.pop_front();
      chk($sformatf("stream%0d level", i), 32'(bus.LEVEL), 10);
      chk($sformatf("stream%0d rvalid", i), 32'(bus.RVALID), 1);
      chk($sformatf("stream%0d rdata", i), 32'(bus.RDATA), 32'(d));
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, '0);
      step();
      d = exp_q.pop_front();
      chk($sformatf("sdrain%0d rdata", i), 32'(bus.RDATA), 32'(d));
    end
    chk("sdrain empty", 32'(bus.LEVEL), 0);

    // Flush at level 30 with a concurrent write
    for (int i = 0; i < 30; i++) push_word(WIDTH'((i + 2) % 8));
    drive(0, 0, 1, 0, '0);
    step();
    d = exp_q.pop_front();
    chk("preclr rdata", 32'(bus.RDATA), 2);
    push_word(3'd6);
    lvl = exp_q.size();
    chk("preclr level", 32'(bus.LEVEL), 32'(lvl));
    drive(1, 1, 0, 0, 3'd1);
    step();
    exp_q.delete();
    chk("clr level", 32'(bus.LEVEL), 0);
    chk("clr empty", 32'(bus.EMPTY), 1);
    chk("clr aempty", 32'(bus.AEMPTY), 1);
    chk("clr rdata kept", 32'(bus.RDATA), 2);
    chk("clr rvalid", 32'(bus.RVALID), 0);
    push_word(3'd4);
    drive(0, 0, 1, 0, '0);
    step();
    d = exp_q.pop_front();
    chk("postclr rdata", 32'(bus.RDATA), 32'(d));
    chk("postclr level", 32'(bus.LEVEL), 0);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) push_word(WIDTH'(i + 5));
    drive(0, 1, 0, 0, 3'd7);
    step();
    drive(0, 1, 1, 0, 3'd2);
    RESET = 1'b0;
    step();
    exp_q.delete();
    chk_reset_state("midreset");
    RESET = 1'b1;
    drive(0, 0, 0, 0, '0);
    step();
    chk_reset_state("postreset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
